// File: rtl/regfile_writeback_pkg.sv
// Shared widths, FIFO entry layout and arbiter selection codes for the writeback slice.
package regfile_writeback_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned RegNumWidth = 5;
  localparam int unsigned WbFifoDepth = 4;

  typedef struct packed {
    logic [RegNumWidth-1:0] rd;
    logic [DataWidth-1:0]   data;
    logic [AddrWidth-1:0]   pc;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO
  } wb_sel_e;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: in-order result FIFO of {rd, data, pc}; also exports per-slot valid and rd for hazard masking.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = WbFifoDepth
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push_i,
  input  wb_entry_t                             push_entry_i,
  input  logic                                  pop_i,
  output wb_entry_t                             head_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic [$clog2(DEPTH):0]                count_o,
  output logic [DEPTH-1:0]                      valid_o,
  output logic [DEPTH*RegNumWidth-1:0]          rd_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrW'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A slot is live when its distance from the read pointer (mod DEPTH) is below the count.
  always_comb begin
    valid_o = '0;
    rd_o    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_o[i] = CntW'(PtrW'(i - 32'(rptr_q))) < count_q;
      rd_o[i*RegNumWidth +: RegNumWidth] = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results vs queued memory results, one registered write per cycle.
// Optional WB_TRACE_EN prints each committed write.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = WbFifoDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   aluValid,
  output logic                   aluReady,
  input  logic [RegNumWidth-1:0] aluRd,
  input  logic [DataWidth-1:0]   aluData,
  input  logic [AddrWidth-1:0]   aluPC,
  input  logic                   memValid,
  output logic                   memReady,
  input  logic [RegNumWidth-1:0] memRd,
  input  logic [DataWidth-1:0]   memData,
  input  logic [AddrWidth-1:0]   memPC,
  output logic                   regWriteEnable,
  output logic [RegNumWidth-1:0] regWriteNum,
  output logic [DataWidth-1:0]   regWriteData,
  output logic [AddrWidth-1:0]   regWritePC,
  output logic [31:0]            pendingMask
);

  wb_entry_t                         push_entry, head;
  logic                              fifo_full, fifo_empty, push, pop, alu_take;
  logic [$clog2(FIFO_DEPTH):0]       fifo_count;
  logic [FIFO_DEPTH-1:0]             fifo_valid;
  logic [FIFO_DEPTH*RegNumWidth-1:0] fifo_rd;
  wb_sel_e                           sel;

  logic                   we_q, we_d;
  logic [RegNumWidth-1:0] num_q, num_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [AddrWidth-1:0]   pc_q, pc_d;

  assign aluReady   = reset && !fifo_full;
  assign memReady   = reset && !fifo_full;
  assign alu_take   = aluValid && aluReady && (aluRd != '0);
  assign push       = memValid && memReady && (memRd != '0);
  assign pop        = (sel == SEL_FIFO);
  assign push_entry = '{rd: memRd, data: memData, pc: memPC};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .valid_o      (fifo_valid),
    .rd_o         (fifo_rd)
  );

  always_comb begin
    sel = SEL_NONE;
    if (alu_take)         sel = SEL_ALU;
    else if (!fifo_empty) sel = SEL_FIFO;
    we_d   = 1'b0;
    num_d  = num_q;
    data_d = data_q;
    pc_d   = pc_q;
    case (sel)
      SEL_ALU: begin
        we_d = 1'b1; num_d = aluRd; data_d = aluData; pc_d = aluPC;
      end
      SEL_FIFO: begin
        we_d = 1'b1; num_d = head.rd; data_d = head.data; pc_d = head.pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      num_q  <= '0;
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      we_q   <= we_d;
      num_q  <= num_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) pendingMask[fifo_rd[i*RegNumWidth +: RegNumWidth]] = 1'b1;
    end
    if (we_q) pendingMask[num_q] = 1'b1;
    pendingMask[0] = 1'b0;
  end

  assign regWriteEnable = we_q;
  assign regWriteNum    = num_q;
  assign regWriteData   = data_q;
  assign regWritePC     = pc_q;

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (regWriteEnable) $display("pc = %h: x%d = %h", regWritePC, regWriteNum, regWriteData);
  end
`else
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based writeback model, plus directed pins.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aluValid = 1'b0, memValid = 1'b0;
  logic [4:0]  aluRd = '0, memRd = '0;
  logic [31:0] aluData = '0, aluPC = '0, memData = '0, memPC = '0;
  logic        aluReady, memReady, regWriteEnable;
  logic [4:0]  regWriteNum;
  logic [31:0] regWriteData, regWritePC, pendingMask;

  regfile_writeback #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData), .aluPC(aluPC),
    .memValid(memValid), .memReady(memReady), .memRd(memRd), .memData(memData), .memPC(memPC),
    .regWriteEnable(regWriteEnable), .regWriteNum(regWriteNum),
    .regWriteData(regWriteData), .regWritePC(regWritePC), .pendingMask(pendingMask)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_num = '0;
  logic [31:0] m_data = '0, m_pc = '0;
  bit          m_alu_acc = 1'b0, m_mem_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (m_we) m[m_num] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_clear();
    q.delete();
    m_we = 1'b0; m_num = '0; m_data = '0; m_pc = '0;
    m_alu_acc = 1'b0; m_mem_acc = 1'b0;
  endtask

  // Writeback rules: ALU (non-x0, not full) wins, else oldest queued result, else idle.
  task automatic model_edge();
    bit full;
    ent_t e;
    if (!reset) begin
      model_clear();
      return;
    end
    full      = (q.size() == D);
    m_alu_acc = aluValid && !full;
    m_mem_acc = memValid && !full;
    if (m_alu_acc && aluRd != 5'd0) begin
      m_we = 1'b1; m_num = aluRd; m_data = aluData; m_pc = aluPC;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_num = e.rd; m_data = e.data; m_pc = e.pc;
    end else begin
      m_we = 1'b0;
    end
    if (m_mem_acc && memRd != 5'd0) q.push_back('{memRd, memData, memPC});
  endtask

  task automatic compare_all();
    logic rdy;
    rdy = reset && (q.size() < D);
    chk("aluReady", 64'(aluReady), 64'(rdy));
    chk("memReady", 64'(memReady), 64'(rdy));
    chk("regWriteEnable", 64'(regWriteEnable), 64'(m_we));
    chk("regWriteNum", 64'(regWriteNum), 64'(m_num));
    chk("regWriteData", 64'(regWriteData), 64'(m_data));
    chk("regWritePC", 64'(regWritePC), 64'(m_pc));
    chk("pendingMask", 64'(pendingMask), 64'(model_mask()));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge: assert reset between edges, hold it over one posedge, release before the next.
  task automatic do_async_reset();
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("rst_we", 64'(regWriteEnable), 64'd0);
    chk("rst_num", 64'(regWriteNum), 64'd0);
    chk("rst_data", 64'(regWriteData), 64'd0);
    chk("rst_pc", 64'(regWritePC), 64'd0);
    chk("rst_mask", 64'(pendingMask), 64'd0);
    chk("rst_aluReady", 64'(aluReady), 64'd0);
    chk("rst_memReady", 64'(memReady), 64'd0);
    cycle();
    #4 reset = 1'b1;
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0; memValid = 1'b0;
    aluRd = '0; memRd = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int alu_pct;
    #1 reset = 1'b0;
    #2;
    chk("init_we", 64'(regWriteEnable), 64'd0);
    chk("init_num", 64'(regWriteNum), 64'd0);
    chk("init_data", 64'(regWriteData), 64'd0);
    chk("init_pc", 64'(regWritePC), 64'd0);
    chk("init_mask", 64'(pendingMask), 64'd0);
    chk("init_aluReady", 64'(aluReady), 64'd0);
    cycle();
    cycle();
    #4 reset = 1'b1;
    cycle();
    chk("post_rst_aluReady", 64'(aluReady), 64'd1);
    chk("post_rst_memReady", 64'(memReady), 64'd1);
    chk("post_rst_mask", 64'(pendingMask), 64'd0);

    // single ALU write
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h1234; aluPC = 32'h100;
    cycle();
    idle_inputs();
    chk("alu_we", 64'(regWriteEnable), 64'd1);
    chk("alu_num", 64'(regWriteNum), 64'd5);
    chk("alu_data", 64'(regWriteData), 64'h1234);
    chk("alu_pc", 64'(regWritePC), 64'h100);
    chk("alu_mask", 64'(pendingMask), 64'h20);
    cycle();
    chk("alu_after_we", 64'(regWriteEnable), 64'd0);
    chk("alu_after_mask", 64'(pendingMask), 64'd0);

    // memory result, latency 2
    memValid = 1'b1; memRd = 5'd7; memData = 32'h77; memPC = 32'h140;
    cycle();
    idle_inputs();
    chk("mem_c1_we", 64'(regWriteEnable), 64'd0);
    chk("mem_c1_mask", 64'(pendingMask), 64'h80);
    cycle();
    chk("mem_c2_we", 64'(regWriteEnable), 64'd1);
    chk("mem_c2_num", 64'(regWriteNum), 64'd7);
    chk("mem_c2_data", 64'(regWriteData), 64'h77);
    cycle();
    chk("mem_c3_mask", 64'(pendingMask), 64'd0);

    // fill FIFO under ALU traffic, then drain
    aluValid = 1'b1; aluRd = 5'd10; aluData = 32'hA0; aluPC = 32'h200;
    memValid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      memRd = 5'(k); memData = 32'(k * 17); memPC = 32'h300 + 32'(k * 4);
      cycle();
      chk("fill_num", 64'(regWriteNum), 64'd10);
    end
    memValid = 1'b0;
    chk("full_memReady", 64'(memReady), 64'd0);
    chk("full_aluReady", 64'(aluReady), 64'd0);
    chk("full_mask", 64'(pendingMask), 64'h41E);
    aluData = 32'hA5;
    cycle();
    chk("drain_head1", 64'(regWriteNum), 64'd1);
    chk("drain_head1_data", 64'(regWriteData), 64'd17);
    chk("drain_aluReady", 64'(aluReady), 64'd1);
    cycle();
    aluValid = 1'b0;
    chk("held_alu_num", 64'(regWriteNum), 64'd10);
    chk("held_alu_data", 64'(regWriteData), 64'hA5);
    for (int k = 2; k <= 4; k++) begin
      cycle();
      chk("drain_head", 64'(regWriteNum), 64'(k));
    end
    cycle();
    chk("drained_we", 64'(regWriteEnable), 64'd0);

    // x0 discards, ALU x0 does not block a pop
    memValid = 1'b1; memRd = 5'd3; memData = 32'h33; memPC = 32'h400;
    cycle();
    aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hFFFF;
    memValid = 1'b1; memRd = 5'd0; memData = 32'hFFFF;
    cycle();
    chk("x0_pop_we", 64'(regWriteEnable), 64'd1);
    chk("x0_pop_num", 64'(regWriteNum), 64'd3);
    chk("x0_pop_data", 64'(regWriteData), 64'h33);
    cycle();
    idle_inputs();
    chk("x0_we", 64'(regWriteEnable), 64'd0);
    chk("x0_mask", 64'(pendingMask), 64'd0);
    cycle();

    // reset with three queued entries
    aluValid = 1'b1; aluRd = 5'd9; aluData = 32'h99;
    memValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      memRd = 5'(11 + k); memData = 32'(k); memPC = 32'h500;
      cycle();
    end
    idle_inputs();
    chk("pre_rst_mask", 64'(pendingMask), 64'h3A00);
    do_async_reset();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("post_rst_we", 64'(regWriteEnable), 64'd0);
    end

    // randomized traffic with hold-until-accepted producers
    for (int n = 0; n < 3000; n++) begin
      alu_pct = (n < 1000) ? 30 : (n < 2000) ? 70 : 95;
      if (!aluValid || m_alu_acc) begin
        aluValid = ($urandom_range(0, 99) < alu_pct);
        aluRd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        aluData  = $urandom;
        aluPC    = $urandom & 32'hFFFF_FFFC;
      end
      if (!memValid || m_mem_acc) begin
        memValid = ($urandom_range(0, 99) < 55);
        memRd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        memData  = $urandom;
        memPC    = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(0, 399) == 0) do_async_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
